// File: rtl/cronometro_pkg.sv
// Shared definitions for the parametrised BCD stopwatch: state encoding, digit limit
// and an all-nines test over a packed digit vector.
package cronometro_pkg;

   typedef enum logic [1:0] {
      StReset  = 2'd0,
      StContar = 2'd1,
      StPausar = 2'd2,
      StParar  = 2'd3
   } estado_e;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int unsigned MaxDigits = 8;

   // Only the low n digits are examined; the vector is zero-padded by the caller.
   function automatic logic all_nines(input logic [4*MaxDigits-1:0] v, input int unsigned n);
      logic r;
      r = 1'b1;
      for (int unsigned i = 0; i < MaxDigits; i++) begin
         if (i < n && v[4*i +: 4] != BCD_MAX) r = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/cronometro_bcd_param_bcd_digito.sv
// One BCD digit of the stopwatch chain: increments on inc_in, rolls 9 -> 0 and
// raises carry_out in that same cycle so the next digit advances together.
module bcd_digito
   import cronometro_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc_in,
   input  logic       sat_hold,
   output logic [3:0] q,
   output logic       carry_out
);

   logic [3:0] q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = 4'd0;
      end else if (inc_in && !sat_hold) begin
         q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) q_q <= 4'd0;
      else       q_q <= q_d;
   end

   assign q         = q_q;
   assign carry_out = inc_in && !sat_hold && (q_q == BCD_MAX);

endmodule

// File: rtl/cronometro_bcd_param.sv
// Multi-digit BCD stopwatch: control FSM, tick prescaler, lap display hold and sticky
// overflow, driving a chain of bcd_digito instances.
module cronometro_bcd_param
   import cronometro_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned TICK_DIV = 5000000,
   parameter bit          WRAP     = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                contar,
   input  logic                pausar,
   input  logic                parar,
   input  logic                zerar,
   output logic [4*DIGITS-1:0] num_saida_display,
   output logic [4*DIGITS-1:0] num_saida_contador,
   output logic [1:0]          estado,
   output logic                tick,
   output logic                overflow
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PresMax = PW'(TICK_DIV - 1);

   estado_e state_d, state_q;
   logic [PW-1:0] presc_d, presc_q;
   logic tick_d, tick_q;
   logic ovf_d, ovf_q;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] display_d, display_q;
   logic [4*MaxDigits-1:0] count_ext;
   logic [DIGITS-1:0] inc_chain, carry;
   logic run, clr, hold_disp, sat_hold, carry_top, ovf_evt;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= StReset;
      else       state_q <= state_d;
   end

   // Next state; parar outranks pausar, which outranks contar
   always_comb begin
      state_d = state_q;
      case (state_q)
         StReset: begin
            if (contar) state_d = StContar;
         end
         StContar: begin
            if (parar)       state_d = StParar;
            else if (pausar) state_d = StPausar;
         end
         StPausar: begin
            if (parar)                  state_d = StParar;
            else if (!pausar && contar) state_d = StContar;
         end
         StParar: begin
            if (zerar)                 state_d = StReset;
            else if (!parar && contar) state_d = StContar;
         end
         default: state_d = StReset;
      endcase
   end

   // FSM-derived controls
   always_comb begin
      run       = (state_q == StContar) || (state_q == StPausar);
      clr       = (state_d == StReset);
      hold_disp = (state_q == StPausar) && (state_d == StPausar);
      estado    = state_q;
   end

   always_comb begin
      tick_d  = run && (presc_q == PresMax);
      presc_d = presc_q;
      if (clr)         presc_d = '0;
      else if (run)    presc_d = tick_d ? '0 : presc_q + 1'b1;
   end

   always_comb begin
      count_ext          = '0;
      count_ext[W-1:0]   = count_q;
      sat_hold           = !WRAP && all_nines(count_ext, DIGITS);
      inc_chain[0]       = tick_d;
      for (int unsigned k = 1; k < DIGITS; k++) inc_chain[k] = carry[k-1];
      carry_top          = carry[DIGITS-1];
      // Wrap mode sees the top carry; saturate mode sees a tick landing on all-nines
      ovf_evt            = carry_top || (sat_hold && tick_d);
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digito u_digit (
         .clock     (clock),
         .reset     (reset),
         .clr       (clr),
         .inc_in    (inc_chain[k]),
         .sat_hold  (sat_hold),
         .q         (count_q[4*k +: 4]),
         .carry_out (carry[k])
      );
   end

   // Mirror of the digit next-value so the display loads on the same edge as the count
   always_comb begin
      count_d = count_q;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (clr) begin
            count_d[4*k +: 4] = 4'd0;
         end else if (inc_chain[k] && !sat_hold) begin
            count_d[4*k +: 4] = (count_q[4*k +: 4] == BCD_MAX) ? 4'd0 : count_q[4*k +: 4] + 4'd1;
         end
      end
      display_d = hold_disp ? display_q : count_d;
      ovf_d     = clr ? 1'b0 : (ovf_q || ovf_evt);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q   <= '0;
         tick_q    <= 1'b0;
         ovf_q     <= 1'b0;
         display_q <= '0;
      end else begin
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         ovf_q     <= ovf_d;
         display_q <= display_d;
      end
   end

   assign num_saida_contador = count_q;
   assign num_saida_display  = display_q;
   assign tick               = tick_q;
   assign overflow           = ovf_q;

endmodule

// File: tb/tb_cronometro_bcd_param.sv
// Bench for cronometro_bcd_param: a wrapping and a saturating 2-digit instance share
// the button stimulus; expected values are queued as stimulus is driven.
module tb_cronometro_bcd_param;

   logic clock = 1'b0;
   logic reset, contar, pausar, parar, zerar;
   logic [7:0] disp_w, cnt_w, disp_s, cnt_s;
   logic [1:0] est_w, est_s;
   logic tick_w, tick_s, ovf_w, ovf_s;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   always #5 clock = ~clock;

   cronometro_bcd_param #(.DIGITS(2), .TICK_DIV(4), .WRAP(1'b1)) u_wrap (
      .clock(clock), .reset(reset), .contar(contar), .pausar(pausar), .parar(parar),
      .zerar(zerar), .num_saida_display(disp_w), .num_saida_contador(cnt_w),
      .estado(est_w), .tick(tick_w), .overflow(ovf_w)
   );

   cronometro_bcd_param #(.DIGITS(2), .TICK_DIV(4), .WRAP(1'b0)) u_sat (
      .clock(clock), .reset(reset), .contar(contar), .pausar(pausar), .parar(parar),
      .zerar(zerar), .num_saida_display(disp_s), .num_saida_contador(cnt_s),
      .estado(est_s), .tick(tick_s), .overflow(ovf_s)
   );

   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_tick(output int gap);
      gap = 0;
      do begin
         step();
         gap++;
      end while (tick_w !== 1'b1 && gap < 50);
      if (tick_w !== 1'b1) gap = -1;
   endtask

   task automatic run_ticks(input int n, output bit ok);
      int g;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         wait_tick(g);
         if (g < 0) ok = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      contar = 0; pausar = 0; parar = 0; zerar = 0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      n_checks++;
      if ({est_w, cnt_w, disp_w, tick_w, ovf_w} !== {2'd0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_wrap: got est=%0d cnt=%h disp=%h tick=%b ovf=%b want all zero",
                  est_w, cnt_w, disp_w, tick_w, ovf_w);
      end
      n_checks++;
      if ({est_s, cnt_s, disp_s, tick_s, ovf_s} !== {2'd0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_sat: got est=%0d cnt=%h disp=%h tick=%b ovf=%b want all zero",
                  est_s, cnt_s, disp_s, tick_s, ovf_s);
      end
   endtask

   task automatic test_count();
      int gap;
      logic [7:0] e;
      contar = 1'b1; step(); contar = 1'b0;
      n_checks++;
      if (est_w !== 2'd1) begin
         n_errors++;
         $display("FAIL count_state: got %0d want 1", est_w);
      end
      for (int k = 1; k <= 10; k++) begin
         exp_q.push_back(to_bcd(k));
         wait_tick(gap);
         n_checks++;
         if (gap !== 4) begin
            n_errors++;
            $display("FAIL count_gap%0d: got %0d want 4", k, gap);
         end
         e = exp_q.pop_front();
         n_checks++;
         if ({cnt_w, disp_w, cnt_s} !== {e, e, e}) begin
            n_errors++;
            $display("FAIL count_val%0d: got cnt=%h disp=%h sat=%h want %h", k, cnt_w, disp_w,
                     cnt_s, e);
         end
      end
   endtask

   task automatic test_lap();
      bit ok;
      logic [7:0] e;
      run_ticks(13, ok);
      n_checks++;
      if (!ok || cnt_w !== 8'h23) begin
         n_errors++;
         $display("FAIL lap_pre: got cnt=%h ok=%b want 23", cnt_w, ok);
      end
      exp_q.push_back(8'h23);
      exp_q.push_back(8'h26);
      pausar = 1'b1; step(); pausar = 1'b0;
      step(12);
      n_checks++;
      if (est_w !== 2'd2) begin
         n_errors++;
         $display("FAIL lap_state: got %0d want 2", est_w);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (disp_w !== e) begin
         n_errors++;
         $display("FAIL lap_disp: got %h want %h", disp_w, e);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (cnt_w !== e) begin
         n_errors++;
         $display("FAIL lap_cnt: got %h want %h", cnt_w, e);
      end
      exp_q.push_back(8'h26);
      contar = 1'b1; step(); contar = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({est_w, disp_w, cnt_w} !== {2'd1, e, e}) begin
         n_errors++;
         $display("FAIL lap_resync: got est=%0d disp=%h cnt=%h want 1 %h %h", est_w, disp_w,
                  cnt_w, e, e);
      end
   endtask

   task automatic test_stop();
      bit ok;
      int gap;
      logic [7:0] e;
      do_reset();
      contar = 1'b1; step(); contar = 1'b0;
      run_ticks(15, ok);
      exp_q.push_back(8'h15);
      step();
      parar = 1'b1; step(); parar = 1'b0;
      step(20);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || {est_w, cnt_w, disp_w, tick_w} !== {2'd3, e, e, 1'b0}) begin
         n_errors++;
         $display("FAIL stop_hold: got est=%0d cnt=%h disp=%h tick=%b ok=%b want 3 %h %h 0",
                  est_w, cnt_w, disp_w, tick_w, ok, e, e);
      end
      exp_q.push_back(8'h16);
      contar = 1'b1; step(); contar = 1'b0;
      wait_tick(gap);
      n_checks++;
      if (gap !== 2) begin
         n_errors++;
         $display("FAIL stop_resume_gap: got %0d want 2", gap);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (cnt_w !== e) begin
         n_errors++;
         $display("FAIL stop_resume_cnt: got %h want %h", cnt_w, e);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int gap;
      do_reset();
      contar = 1'b1; step(); contar = 1'b0;
      run_ticks(99, ok);
      n_checks++;
      if (!ok || {cnt_w, cnt_s, ovf_w, ovf_s} !== {8'h99, 8'h99, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL ovf_pre: got w=%h s=%h ovf=%b%b ok=%b want 99 99 00", cnt_w, cnt_s,
                  ovf_w, ovf_s, ok);
      end
      wait_tick(gap);
      n_checks++;
      if (gap < 0 || {cnt_w, ovf_w} !== {8'h00, 1'b1}) begin
         n_errors++;
         $display("FAIL ovf_wrap: got cnt=%h ovf=%b gap=%0d want 00 1", cnt_w, ovf_w, gap);
      end
      n_checks++;
      if ({cnt_s, disp_s, ovf_s} !== {8'h99, 8'h99, 1'b1}) begin
         n_errors++;
         $display("FAIL ovf_sat: got cnt=%h disp=%h ovf=%b want 99 99 1", cnt_s, disp_s, ovf_s);
      end
      step(20);
      n_checks++;
      if ({cnt_s, ovf_s} !== {8'h99, 1'b1}) begin
         n_errors++;
         $display("FAIL ovf_sat_hold: got cnt=%h ovf=%b want 99 1", cnt_s, ovf_s);
      end
      n_checks++;
      if ({cnt_w, ovf_w} !== {8'h05, 1'b1}) begin
         n_errors++;
         $display("FAIL ovf_wrap_run: got cnt=%h ovf=%b want 05 1", cnt_w, ovf_w);
      end
      parar = 1'b1; step(); parar = 1'b0;
      zerar = 1'b1; step(); zerar = 1'b0;
      n_checks++;
      if ({est_w, cnt_w, disp_w, ovf_w, est_s, cnt_s, disp_s, ovf_s} !==
          {2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0}) begin
         n_errors++;
         $display("FAIL ovf_zerar: got w=%0d/%h/%h/%b s=%0d/%h/%h/%b want all zero", est_w,
                  cnt_w, disp_w, ovf_w, est_s, cnt_s, disp_s, ovf_s);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      logic [7:0] e;
      contar = 1'b1; step(); contar = 1'b0;
      parar = 1'b1; pausar = 1'b1; step(); parar = 1'b0; pausar = 1'b0;
      n_checks++;
      if (est_w !== 2'd3) begin
         n_errors++;
         $display("FAIL sim_parar_pausar: got %0d want 3", est_w);
      end
      zerar = 1'b1; contar = 1'b1; step(); zerar = 1'b0; contar = 1'b0;
      n_checks++;
      if ({est_w, cnt_w} !== {2'd0, 8'h00}) begin
         n_errors++;
         $display("FAIL sim_zerar_contar: got est=%0d cnt=%h want 0 00", est_w, cnt_w);
      end
      contar = 1'b1; step(); contar = 1'b0;
      run_ticks(41, ok);
      exp_q.push_back(8'h42);
      step(3);
      // pausar lands on the tick edge, so the frozen display must include that tick
      pausar = 1'b1; step(); pausar = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || {est_w, tick_w, disp_w, cnt_w} !== {2'd2, 1'b1, e, e}) begin
         n_errors++;
         $display("FAIL sim_pause_tick: got est=%0d tick=%b disp=%h cnt=%h ok=%b want 2 1 %h",
                  est_w, tick_w, disp_w, cnt_w, ok, e);
      end
      step(2);
      reset = 1'b1; step(); reset = 1'b0;
      n_checks++;
      if ({est_w, cnt_w, disp_w, tick_w, ovf_w} !== {2'd0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL sim_reset_pausar: got est=%0d cnt=%h disp=%h tick=%b ovf=%b want zero",
                  est_w, cnt_w, disp_w, tick_w, ovf_w);
      end
   endtask

   initial begin
      reset = 1'b1; contar = 1'b0; pausar = 1'b0; parar = 1'b0; zerar = 1'b0;
      test_reset();
      test_count();
      test_lap();
      test_stop();
      test_overflow();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/cronometro_bcd_param.md
Name: cronometro_bcd_param

Overview:
Parametrised successor of the single-digit stopwatch counter. It is a multi-digit BCD stopwatch with a built-in tick prescaler, lap (split) display hold, stop/resume, soft clear and overflow reporting. It sits between the debounced button inputs and the 7-segment decoder bank. It drives one BCD nibble per display digit plus a free-running internal count.

Parameters:
DIGITS, 4, number of BCD digits (1..8); outputs are 4*DIGITS bits wide
TICK_DIV, 5000000, clock cycles per count increment (>=2)
WRAP, 1, 1 = wrap all-9s to all-0s; 0 = saturate at all-9s

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
contar  in  1  start/resume counting, level-sampled
pausar  in  1  lap: counting continues, display frozen
parar  in  1  stop counting
zerar  in  1  soft clear, accepted only in PARAR
num_saida_display  out  4*DIGITS  BCD value shown on display, digit 0 in bits [3:0]
num_saida_contador  out  4*DIGITS  live BCD count
estado  out  2  current state: 0 RESET, 1 CONTAR, 2 PAUSAR, 3 PARAR
tick  out  1  one-cycle pulse on each count increment
overflow  out  1  sticky overflow flag

Behaviour:
- Reset: the clock and reset ports are named as in the codebase. Reset is synchronous and active-high. It has top priority and applies on the next rising edge regardless of state. After reset: estado=RESET, both BCD outputs=0, prescaler=0, tick=0, overflow=0. No initial blocks are used.
- State transitions, evaluated each edge. Input priority in every state: parar > pausar > contar.
  - RESET: contar -> CONTAR. pausar and parar are ignored.
  - CONTAR: parar -> PARAR; pausar -> PAUSAR.
  - PAUSAR: parar -> PARAR; contar -> CONTAR. pausar held stays in PAUSAR.
  - PARAR: zerar -> RESET (zerar has priority over contar); contar -> CONTAR.
- Prescaler: runs in CONTAR and PAUSAR. Range 0..TICK_DIV-1.
  - When it equals TICK_DIV-1, it returns to 0 and asserts tick for exactly that cycle.
  - In PARAR it holds its value; resuming continues the partial period.
  - In RESET it is cleared.
- Tick latency: the count increments on the same edge that registers tick=1. num_saida_contador reflects the new value in the cycle tick is high.
- BCD chain:
  - Digit 0 increments on tick.
  - Digit k increments when tick is high and digits 0..k-1 are all 9.
  - A digit at 9 that increments becomes 0.
  - No digit ever holds a value >9.
- Overflow: occurs when a tick arrives while all digits are 9.
  - WRAP=1: all digits become 0.
  - WRAP=0: all digits stay 9, and later ticks have no effect on the count.
  - In both modes overflow is set, and it stays set until reset or zerar.
- Display:
  - CONTAR and PARAR: num_saida_display equals num_saida_contador every cycle. It is registered from the same next-value as the counter.
  - PAUSAR: num_saida_display holds the value present on the PAUSAR entry edge, while num_saida_contador continues to advance.
  - Leaving PAUSAR for CONTAR or PARAR: the display resynchronises to the live count on the transition edge.
- Simultaneous events:
  - A tick on the same edge as CONTAR->PARAR is applied, so the last increment is not lost.
  - A tick on the same edge as CONTAR->PAUSAR is applied, and the frozen display includes it.
  - zerar together with contar in PARAR results in RESET.
- Reset mid-count: all state, count, prescaler and flag clear on that edge.

Decomposition:
- Shared package cronometro_pkg holds:
  - the 2-bit state encoding constants (RESET, CONTAR, PAUSAR, PARAR);
  - the BCD_MAX=4'd9 constant;
  - a function to test a digit vector for all-9s.
- One sub-module, bcd_digito, is natural. Ports: clock, reset, clr, inc_in, sat_hold, q[3:0], carry_out. It is instantiated DIGITS times in a generate loop.
- The top level holds the FSM, the prescaler, the display register and the overflow logic.

Test Plan:
1. DIGITS=2, TICK_DIV=4: reset, then pulse contar. Expect tick every 4 cycles, and the counter reads 0x01, 0x02 … 0x09, 0x10 after 40 cycles. The display tracks the counter.
2. Count to 0x23, pulse pausar, run 12 cycles. Expect display=0x23, counter=0x26. Pulse contar: display=counter on that edge.
3. Count to 0x15 plus 2 prescaler cycles, pulse parar, hold 20 cycles: count stays 0x15. Pulse contar: the next tick arrives after 2 cycles, not 4.
4. WRAP=1: count reaches 0x99, next tick -> 0x00 with overflow=1. In PARAR, pulse zerar -> RESET, overflow=0, outputs 0x00.
5. WRAP=0: count reaches 0x99, run 20 more cycles -> still 0x99 with overflow=1.
6. Assert parar and pausar together in CONTAR -> PARAR. Assert reset while in PAUSAR at 0x42 -> next edge all outputs 0 and estado=0.
